// File: rtl/scalar_rf_write_sequencer.sv
// Write-port sequencer for the scalar register file: zero-fills every register
// after reset or on request, then arbitrates pipeline writeback against host writes.
module scalar_rf_write_sequencer #(
    parameter int          NUM_REGS      = 128,
    parameter int          REG_IDX_WIDTH = 7,
    parameter logic [31:0] CLEAR_VALUE   = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic                     wb_enable_scalar_writeback,
    input  logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
    input  logic [31:0]              wb_writeback_value,
    input  logic                     host_wr_valid,
    input  logic [REG_IDX_WIDTH-1:0] host_wr_reg,
    input  logic [31:0]              host_wr_value,
    output logic                     host_wr_ready,
    output logic                     rf_enable_scalar_writeback,
    output logic [REG_IDX_WIDTH-1:0] rf_writeback_reg,
    output logic [31:0]              rf_writeback_value,
    output logic                     init_busy,
    output logic                     wb_drop_err
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [REG_IDX_WIDTH-1:0] LAST_IDX = REG_IDX_WIDTH'(NUM_REGS - 1);

    state_t                   state_q, state_d;
    logic [REG_IDX_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [REG_IDX_WIDTH-1:0] issue_idx;
    logic                     rf_en_q, rf_en_d;
    logic [REG_IDX_WIDTH-1:0] rf_reg_q, rf_reg_d;
    logic [31:0]              rf_val_q, rf_val_d;
    logic                     busy_q, busy_d;
    logic                     drop_q, drop_d;

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        rf_en_d       = 1'b0;
        rf_reg_d      = rf_reg_q;
        rf_val_d      = rf_val_q;
        busy_d        = busy_q;
        drop_d        = drop_q;
        host_wr_ready = (state_q == ST_IDLE) && !wb_enable_scalar_writeback && !clear_req;
        // A restart request writes index 0 on the same edge, so the counter moves on to 1.
        issue_idx     = clear_req ? '0 : clr_idx_q;

        unique case (state_q)
            ST_CLEAR: begin
                rf_en_d  = 1'b1;
                rf_reg_d = issue_idx;
                rf_val_d = CLEAR_VALUE;
                if (wb_enable_scalar_writeback) drop_d = 1'b1;
                if (issue_idx == LAST_IDX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_idx_d = issue_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (wb_enable_scalar_writeback) begin
                    rf_en_d  = 1'b1;
                    rf_reg_d = wb_writeback_reg;
                    rf_val_d = wb_writeback_value;
                end else if (host_wr_valid && host_wr_ready) begin
                    rf_en_d  = 1'b1;
                    rf_reg_d = host_wr_reg;
                    rf_val_d = host_wr_value;
                end
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            rf_en_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_val_q  <= '0;
            busy_q    <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rf_en_q   <= rf_en_d;
            rf_reg_q  <= rf_reg_d;
            rf_val_q  <= rf_val_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign rf_enable_scalar_writeback = rf_en_q;
    assign rf_writeback_reg           = rf_reg_q;
    assign rf_writeback_value         = rf_val_q;
    assign init_busy                  = busy_q;
    assign wb_drop_err                = drop_q;

endmodule
